// File: rtl/cpu_bus1_master.sv
// rtl/cpu_bus1_master.sv - bus1 (A1/D1/C1) initiator: serialises one CPU request, then collects the cache response.
module cpu_bus1_master #(
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 3,
    parameter int TIMEOUT           = 255
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [CTR1_BUS_SIZE-1:0]                  req_cmd,
    input  logic [ADDR1_BUS_SIZE+CACHE_OFFSET_SIZE-1:0] req_addr,
    input  logic [2*DATA1_BUS_SIZE-1:0]               req_wdata,
    output logic                                      resp_valid,
    output logic [2*DATA1_BUS_SIZE-1:0]               resp_rdata,
    output logic                                      resp_err,
    output wire  [ADDR1_BUS_SIZE-1:0]                 A1_WIRE,
    inout  wire  [DATA1_BUS_SIZE-1:0]                 D1_WIRE,
    inout  wire  [CTR1_BUS_SIZE-1:0]                  C1_WIRE
);

    localparam int ADDR_W = ADDR1_BUS_SIZE + CACHE_OFFSET_SIZE;
    localparam int DW     = DATA1_BUS_SIZE;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [CTR1_BUS_SIZE-1:0] CMD_NOP        = CTR1_BUS_SIZE'(0);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ8      = CTR1_BUS_SIZE'(1);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ16     = CTR1_BUS_SIZE'(2);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_READ32     = CTR1_BUS_SIZE'(3);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE8     = CTR1_BUS_SIZE'(5);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE16    = CTR1_BUS_SIZE'(6);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_WRITE32    = CTR1_BUS_SIZE'(7);
    localparam logic [CTR1_BUS_SIZE-1:0] CMD_RESPONSE   = CTR1_BUS_SIZE'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TICK1,
        S_TICK2,
        S_WAIT,
        S_BEAT2,
        S_DONE
    } state_t;

    state_t                      state;
    logic [CTR1_BUS_SIZE-1:0]    cmd_q;
    logic [CACHE_OFFSET_SIZE-1:0] offset_q;
    logic [DW-1:0]               wdata_hi_q;
    logic [DW-1:0]               rdata_lo_q;
    logic [CNT_W-1:0]            cnt;

    logic                        a1_oe;
    logic                        d1_oe;
    logic                        c1_oe;
    logic [ADDR1_BUS_SIZE-1:0]   a1_q;
    logic [DW-1:0]               d1_q;
    logic [CTR1_BUS_SIZE-1:0]    c1_q;

    function automatic logic is_read(input logic [CTR1_BUS_SIZE-1:0] c);
        return (c == CMD_READ8) || (c == CMD_READ16) || (c == CMD_READ32);
    endfunction

    function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] c);
        return (c == CMD_WRITE8) || (c == CMD_WRITE16) || (c == CMD_WRITE32);
    endfunction

    assign A1_WIRE = a1_oe ? a1_q : 'z;
    assign D1_WIRE = d1_oe ? d1_q : 'z;
    assign C1_WIRE = c1_oe ? c1_q : 'z;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            cnt        <= '0;
            cmd_q      <= CMD_NOP;
            offset_q   <= '0;
            wdata_hi_q <= '0;
            rdata_lo_q <= '0;
            a1_oe      <= 1'b0;
            d1_oe      <= 1'b0;
            c1_oe      <= 1'b0;
            a1_q       <= '0;
            d1_q       <= '0;
            c1_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && (req_cmd != CMD_NOP)) begin
                        cmd_q      <= req_cmd;
                        offset_q   <= req_addr[CACHE_OFFSET_SIZE-1:0];
                        wdata_hi_q <= req_wdata[2*DW-1:DW];
                        rdata_lo_q <= '0;
                        cnt        <= '0;
                        req_ready  <= 1'b0;
                        c1_oe      <= 1'b1;
                        c1_q       <= req_cmd;
                        a1_oe      <= 1'b1;
                        a1_q       <= req_addr[ADDR_W-1:CACHE_OFFSET_SIZE];
                        d1_oe      <= is_write(req_cmd);
                        d1_q       <= req_wdata[DW-1:0];
                        state      <= S_TICK1;
                    end
                end
                S_TICK1: begin
                    a1_q  <= ADDR1_BUS_SIZE'(offset_q);
                    d1_oe <= (cmd_q == CMD_WRITE32);
                    d1_q  <= wdata_hi_q;
                    state <= S_TICK2;
                end
                S_TICK2: begin
                    // Release everything here so the responder gets a full turnaround cycle.
                    c1_oe <= 1'b0;
                    a1_oe <= 1'b0;
                    d1_oe <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (C1_WIRE == CMD_RESPONSE) begin
                        if (cmd_q == CMD_READ32) begin
                            rdata_lo_q <= D1_WIRE;
                            state      <= S_BEAT2;
                        end else begin
                            if (cmd_q == CMD_READ8)
                                resp_rdata <= {{(2*DW-8){1'b0}}, D1_WIRE[7:0]};
                            else if (is_read(cmd_q))
                                resp_rdata <= {{DW{1'b0}}, D1_WIRE};
                            else
                                resp_rdata <= '0;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_BEAT2: begin
                    resp_rdata <= {D1_WIRE, rdata_lo_q};
                    resp_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    c1_oe     <= 1'b0;
                    a1_oe     <= 1'b0;
                    d1_oe     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus1_master.sv
// tb/tb_cpu_bus1_master.sv - directed bench for cpu_bus1_master with a queued response scoreboard.
module tb_cpu_bus1_master;

    localparam int AW = 15;
    localparam int OW = 4;
    localparam int DW = 16;
    localparam int CW = 3;

    localparam logic [2:0] READ8   = 3'd1;
    localparam logic [2:0] READ16  = 3'd2;
    localparam logic [2:0] READ32  = 3'd3;
    localparam logic [2:0] INVAL   = 3'd4;
    localparam logic [2:0] WRITE8  = 3'd5;
    localparam logic [2:0] WRITE32 = 3'd7;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [CW-1:0]     req_cmd = '0;
    logic [AW+OW-1:0]  req_addr = '0;
    logic [2*DW-1:0]   req_wdata = '0;
    logic              resp_valid;
    logic [2*DW-1:0]   resp_rdata;
    logic              resp_err;
    wire  [AW-1:0]     A1_WIRE;
    wire  [DW-1:0]     D1_WIRE;
    wire  [CW-1:0]     C1_WIRE;

    logic              rsp_c1_oe = 1'b0;
    logic              rsp_d1_oe = 1'b0;
    logic [CW-1:0]     rsp_c1 = '0;
    logic [DW-1:0]     rsp_d1 = '0;

    assign C1_WIRE = rsp_c1_oe ? rsp_c1 : 'z;
    assign D1_WIRE = rsp_d1_oe ? rsp_d1 : 'z;

    int n_checks = 0;
    int n_pass = 0;
    logic [32:0] exp_q[$];

    logic        mon_prev = 1'b0;
    logic [31:0] mon_last = '0;
    logic [32:0] mon_e;

    cpu_bus1_master #(
        .ADDR1_BUS_SIZE    (AW),
        .CACHE_OFFSET_SIZE (OW),
        .DATA1_BUS_SIZE    (DW),
        .CTR1_BUS_SIZE     (CW),
        .TIMEOUT           (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .A1_WIRE    (A1_WIRE),
        .D1_WIRE    (D1_WIRE),
        .C1_WIRE    (C1_WIRE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // A released line reads as z in a four-state simulator and as 0 in a two-state one.
    task automatic check_free(input string name, input logic [31:0] v);
        n_checks++;
        if ($isunknown(v) || v == 32'd0) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected released bus", name, v);
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_q.push_back({exp_err, exp_rdata});
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    // Entered at the TICK1 negedge, returns at the first WAIT negedge.
    task automatic check_ticks(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata);
        logic [31:0] a_hi;
        logic [31:0] a_lo;
        a_hi = {17'd0, addr[18:4]};
        a_lo = {28'd0, addr[3:0]};
        check("tick1_c1", {29'd0, C1_WIRE}, {29'd0, cmd});
        check("tick1_a1", {17'd0, A1_WIRE}, a_hi);
        if (cmd >= WRITE8) check("tick1_d1", {16'd0, D1_WIRE}, {16'd0, wdata[15:0]});
        else check_free("tick1_d1_free", {16'd0, D1_WIRE});
        check("busy_not_ready", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        check("tick2_c1", {29'd0, C1_WIRE}, {29'd0, cmd});
        check("tick2_a1", {17'd0, A1_WIRE}, a_lo);
        if (cmd == WRITE32) check("tick2_d1", {16'd0, D1_WIRE}, {16'd0, wdata[31:16]});
        else check_free("tick2_d1_free", {16'd0, D1_WIRE});
        @(negedge CLK);
        check_free("release_c1", {29'd0, C1_WIRE});
        check_free("release_a1", {17'd0, A1_WIRE});
        check_free("release_d1", {16'd0, D1_WIRE});
    endtask

    // Entered at the first WAIT negedge, returns at the DONE negedge.
    task automatic respond(input logic [2:0] cmd, input int delay, input logic [15:0] beat1,
                           input logic [15:0] beat2);
        for (int i = 0; i < delay; i++) begin
            @(negedge CLK);
            check_free("wait_c1", {29'd0, C1_WIRE});
            check_free("wait_a1", {17'd0, A1_WIRE});
            check("wait_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        rsp_c1_oe = 1'b1;
        rsp_c1    = 3'd7;
        rsp_d1_oe = 1'b1;
        rsp_d1    = beat1;
        #1;
        check("rsp_c1_uncontended", {29'd0, C1_WIRE}, 32'd7);
        check("rsp_d1_uncontended", {16'd0, D1_WIRE}, {16'd0, beat1});
        @(negedge CLK);
        rsp_c1_oe = 1'b0;
        if (cmd == READ32) begin
            check("beat2_no_resp", {31'd0, resp_valid}, 32'd0);
            rsp_d1 = beat2;
            @(negedge CLK);
        end
        rsp_d1_oe = 1'b0;
        check("resp_latency", {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic run_txn(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [15:0] beat1, input logic [15:0] beat2,
                           input logic [31:0] exp_rdata);
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        issue(cmd, addr, wdata, exp_rdata, 1'b0);
        @(negedge CLK);
        req_valid = 1'b0;
        check_ticks(cmd, addr, wdata);
        respond(cmd, delay, beat1, beat2);
        @(negedge CLK);
        check("ready_after_done", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (mon_prev) begin
                check("pulse_width", {31'd0, resp_valid}, 32'd0);
                check("err_clear", {31'd0, resp_err}, 32'd0);
                check("rdata_hold", resp_rdata, mon_last);
            end
            mon_prev = resp_valid;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: resp_valid=1 rdata=0x%0h with nothing outstanding", resp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, mon_e[31:0]);
                    check("resp_err", {31'd0, resp_err}, {31'd0, mon_e[32]});
                    mon_last = mon_e[31:0];
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check_free("rst_c1", {29'd0, C1_WIRE});
        check_free("rst_a1", {17'd0, A1_WIRE});
        check_free("rst_d1", {16'd0, D1_WIRE});
        RESET = 1'b0;
        @(negedge CLK);

        // NOP request is ignored.
        req_valid = 1'b1;
        req_cmd   = 3'd0;
        req_addr  = 19'h00023;
        @(negedge CLK);
        req_valid = 1'b0;
        check("nop_ready", {31'd0, req_ready}, 32'd1);
        check_free("nop_c1", {29'd0, C1_WIRE});
        @(negedge CLK);

        run_txn(READ32, 19'h00023, 32'h0, 0, 16'hBEEF, 16'hDEAD, 32'hDEADBEEF);
        run_txn(WRITE32, 19'h00023, 32'h12345678, 4, 16'h5555, 16'h0, 32'h0);
        run_txn(READ8, 19'h001A7, 32'h0, 0, 16'hABCD, 16'h0, 32'h000000CD);
        run_txn(READ16, 19'h001A7, 32'h0, 0, 16'hABCD, 16'h0, 32'h0000ABCD);
        run_txn(WRITE8, 19'h7FFFF, 32'hFFFFFF5A, 1, 16'h0000, 16'h0, 32'h0);

        // Invalidate with no response: error after exactly 8 WAIT cycles.
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        issue(INVAL, 19'h00050, 32'h0, 32'h0, 1'b1);
        @(negedge CLK);
        req_valid = 1'b0;
        check_ticks(INVAL, 19'h00050, 32'h0);
        for (int i = 1; i < 8; i++) begin
            @(negedge CLK);
            check_free("to_wait_c1", {29'd0, C1_WIRE});
            check_free("to_wait_a1", {17'd0, A1_WIRE});
            check_free("to_wait_d1", {16'd0, D1_WIRE});
            check("to_wait_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        @(negedge CLK);
        check("timeout_resp", {31'd0, resp_valid}, 32'd1);
        @(negedge CLK);
        check("ready_after_timeout", {31'd0, req_ready}, 32'd1);

        // Reset during WAIT of a READ32 aborts silently.
        req_cmd   = READ32;
        req_addr  = 19'h00023;
        req_wdata = 32'h0;
        req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        check_ticks(READ32, 19'h00023, 32'h0);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        check_free("abort_c1", {29'd0, C1_WIRE});
        check_free("abort_a1", {17'd0, A1_WIRE});
        check_free("abort_d1", {16'd0, D1_WIRE});
        repeat (3) begin
            @(negedge CLK);
            check("abort_quiet", {31'd0, resp_valid}, 32'd0);
        end
        run_txn(READ8, 19'h00023, 32'h0, 1, 16'h1234, 16'h0, 32'h00000034);

        // req_valid held across two requests.
        check("idle_ready", {31'd0, req_ready}, 32'd1);
        issue(WRITE8, 19'h00051, 32'h000000A5, 32'h0, 1'b0);
        @(negedge CLK);
        check_ticks(WRITE8, 19'h00051, 32'h000000A5);
        respond(WRITE8, 0, 16'h0000, 16'h0);
        check("b2b_busy_in_done", {31'd0, req_ready}, 32'd0);
        issue(READ16, 19'h00104, 32'h0, 32'h00001357, 1'b0);
        @(negedge CLK);
        check("b2b_ready", {31'd0, req_ready}, 32'd1);
        check_free("b2b_idle_c1", {29'd0, C1_WIRE});
        @(negedge CLK);
        req_valid = 1'b0;
        check_ticks(READ16, 19'h00104, 32'h0);
        respond(READ16, 0, 16'h1357, 16'h0);
        @(negedge CLK);
        check("ready_after_b2b", {31'd0, req_ready}, 32'd1);

        repeat (2) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
